esp_uart_tx: RTL and testbench



---
 rtl/esp_uart_tx.sv | 235 +++++++++++++++++++++++
 tb/tb_esp_uart_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/esp_uart_tx.sv
// esp_uart_tx
//   Byte sink (AXI-stream style valid/ready) that feeds an 8N1 UART transmitter
//   driving the ESP serial link. Bytes are buffered in a small circular FIFO and
//   sent back-to-back with no idle gap between frames.
//
//   Build option: define ESP_UART_TX_PARITY_EN to insert an even-parity bit
//   between data bit 7 and the stop bit (frames become 11 bit-times long).
//
//   Parameters:
//     CLK_FREQ_HZ  input clock frequency
//     BAUD_RATE    line rate; per-bit divisor DIV = round(CLK_FREQ_HZ/BAUD_RATE), DIV >= 2
//     FIFO_DEPTH   byte FIFO depth, power of 2, >= 2
//
//   Ports:
//     clk_i         clock
//     reset_n_i     asynchronous active-low reset
//     valid_i       byte valid
//     data_i        byte, sampled on the edge where valid_i & ready_o
//     ready_o       high when the FIFO has room (decoded from the registered count)
//     tx_serial_o   UART line, idles high
//     busy_o        high while a frame is on the line
//     fifo_count_o  bytes currently buffered
//
//   state  | meaning
//   IDLE   | line high, waiting for a buffered byte
//   START  | start bit (low) for DIV cycles
//   DATA   | data bits, LSB first, DIV cycles each
//   PARITY | even-parity bit for DIV cycles (parity build only)
//   STOP   | stop bit (high) for DIV cycles, then next byte or IDLE

module esp_uart_tx #(
  parameter int CLK_FREQ_HZ = 25000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        valid_i,
  input  logic [7:0]                  data_i,
  output logic                        ready_o,
  output logic                        tx_serial_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

  localparam int DIV   = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  generate
    if (DIV < 2) begin : g_div_chk
      $error("esp_uart_tx: baud divisor must be >= 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
      $error("esp_uart_tx: FIFO_DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef ESP_UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_e;

  // FIFO
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;

  // Transmitter
  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;

  logic             fifo_nonempty;
  logic             bit_end;
  logic [2:0]       idx_inc;

  assign ready_o       = (count_q != FULL_CNT);
  assign push          = valid_i & ready_o;
  assign fifo_nonempty = (count_q != '0);
  assign bit_end       = (cnt_q == DIV_LAST);
  assign idx_inc       = idx_q + 3'd1;

  assign tx_serial_o  = tx_q;
  assign busy_o       = busy_q;
  assign fifo_count_o = count_q;

  // Storage is not reset; contents are dead once the pointers are cleared.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    pop     = 1'b0;

    // Baud counter free-runs 0..DIV-1 while a frame is on the line.
    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + DIV_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          idx_d   = '0;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
`ifdef ESP_UART_TX_PARITY_EN
            tx_d    = ^shift_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_inc;
            tx_d  = shift_q[idx_inc];
          end
        end
      end

`ifdef ESP_UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit when more bytes are waiting.
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            idx_d   = '0;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_esp_uart_tx.sv
module tb_esp_uart_tx;

  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int DEPTH  = 4;
  localparam int DIV    = 10;
`ifdef ESP_UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam int NB  = 11;
`else
  localparam bit PAR = 1'b0;
  localparam int NB  = 10;
`endif
  localparam int F = NB * DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic [7:0] data;
  logic       ready;
  logic       tx;
  logic       busy;
  logic [2:0] count;

  always #5 clk = ~clk;

  esp_uart_tx #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE  (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (rst_n),
    .valid_i     (valid),
    .data_i      (data),
    .ready_o     (ready),
    .tx_serial_o (tx),
    .busy_o      (busy),
    .fifo_count_o(count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: accepted bytes in, decoded bytes out.
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    if (rst_n && valid && ready) exp_q.push_back(data);
  end

  bit         mon_act = 1'b0;
  int         mon_cnt;
  int         mon_k;
  logic [7:0] mon_byte;
  logic       mon_par;
  logic [7:0] mon_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (tx == 1'b0) begin
        mon_act = 1'b1;
        mon_cnt = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % DIV == DIV / 2) begin
        mon_k = mon_cnt / DIV;
        if (mon_k >= 1 && mon_k <= 8) begin
          mon_byte[mon_k-1] = tx;
        end else if (PAR && mon_k == 9) begin
          mon_par = tx;
        end else if (mon_k == NB - 1) begin
          chk("mon_stop", int'(tx), 1);
          if (PAR) chk("mon_parity", int'(mon_par), int'(^mon_byte));
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_byte", int'(mon_byte), -1);
          end else begin
            mon_exp = exp_q.pop_front();
            chk("sb_byte", int'(mon_byte), int'(mon_exp));
          end
          mon_act = 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic [7:0] din;
    logic [9:0] frame;  // 8N1 line bits, index 0 = start bit
    logic       par;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int id, input vec_t v);
    int   lvl_bad;
    logic e;
    @(negedge clk);
    valid = 1'b1;
    data  = v.din;
    @(posedge clk);
    #1;
    valid = 1'b0;
    data  = ~v.din;
    for (int b = 0; b < NB; b++) begin
      if (b < 9)           e = v.frame[b];
      else if (b == NB-1)  e = 1'b1;
      else                 e = v.par;
      lvl_bad = 0;
      for (int j = 0; j < DIV; j++) begin
        @(posedge clk);
        #1;
        if (tx !== e || busy !== 1'b1) lvl_bad++;
      end
      chk($sformatf("vec%0d_bit%0d_bad_cycles", id, b), lvl_bad, 0);
    end
    @(posedge clk);
    #1;
    chk($sformatf("vec%0d_busy_fall", id), int'(busy), 0);
    chk($sformatf("vec%0d_tx_idle", id), int'(tx), 1);
  endtask

  task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    @(negedge clk); valid = 1'b1; data = a;
    @(negedge clk); data = b;
    @(negedge clk); data = c;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk);
      #1;
      if (!busy && count == 0) done = 1'b1;
    end
    chk({name, "_idle_timeout"}, int'(done), 1);
  endtask

  int   nbad;
  int   nxt;
  logic rdy_s;

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    data  = 8'h00;

    repeat (5) @(posedge clk);
    #1;
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(ready), 1);
    chk("rst_count", int'(count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    nbad = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1 || busy !== 1'b0 || count !== 3'd0) nbad++;
    end
    chk("idle_100_bad_cycles", nbad, 0);

    vecs[0] = '{din: 8'h55, frame: 10'b1_01010101_0, par: 1'b0};
    vecs[1] = '{din: 8'h07, frame: 10'b1_00000111_0, par: 1'b1};
    vecs[2] = '{din: 8'h03, frame: 10'b1_00000011_0, par: 1'b0};
    vecs[3] = '{din: 8'hA3, frame: 10'b1_10100011_0, par: 1'b0};
    vecs[4] = '{din: 8'h00, frame: 10'b1_00000000_0, par: 1'b0};
    vecs[5] = '{din: 8'h80, frame: 10'b1_10000000_0, par: 1'b1};
    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Back-to-back frames: busy high continuously for three frame times.
    push3(8'hA3, 8'h0F, 8'hFF);
    nbad = (busy !== 1'b1) ? 1 : 0;
    for (int i = 3; i <= 3 * F; i++) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b1) nbad++;
    end
    chk("b2b_busy_gap_cycles", nbad, 0);
    @(posedge clk);
    #1;
    chk("b2b_busy_fall", int'(busy), 0);
    wait_idle("b2b");

    // Backpressure: hold valid with an incrementing byte until 8 are accepted.
    nxt = 0;
    for (int cyc = 0; cyc < 4 * F && nxt < 8; cyc++) begin
      @(negedge clk);
      valid = 1'b1;
      data  = nxt[7:0];
      rdy_s = ready;
      @(posedge clk);
      if (rdy_s) nxt++;
      #1;
      if (cyc == 1) chk("bp_count_push_pop", int'(count), 1);
      if (cyc == 3) chk("bp_count_c3", int'(count), 3);
      if (cyc == 4) begin
        chk("bp_count_full", int'(count), 4);
        chk("bp_ready_full", int'(ready), 0);
      end
      if (cyc == F) begin
        chk("bp_count_hold", int'(count), 4);
        chk("bp_ready_hold", int'(ready), 0);
      end
      if (cyc == F + 1) begin
        chk("bp_count_after_pop", int'(count), 3);
        chk("bp_ready_after_pop", int'(ready), 1);
      end
      if (cyc == F + 2) begin
        chk("bp_count_refill", int'(count), 4);
        chk("bp_ready_refill", int'(ready), 0);
      end
    end
    valid = 1'b0;
    chk("bp_accepted", nxt, 8);
    wait_idle("bp");
    chk("sb_leftover", exp_q.size(), 0);

    // Reset during data bit 3 of 0x81 with two bytes still queued.
    push3(8'h81, 8'h11, 8'h22);
    repeat (42) @(posedge clk);
    #3;
    chk("mid_tx_bit3", int'(tx), 0);
    chk("mid_count", int'(count), 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", int'(tx), 1);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ready", int'(ready), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    nbad = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1 || busy !== 1'b0 || count !== 3'd0) nbad++;
    end
    chk("post_rst_idle_bad_cycles", nbad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
